regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file with two combinational read ports, one synchronous write-back port and a per-register busy scoreboard.
- Sits between decode/issue and write-back of the pipelined RISC-V core.
- Issue marks the destination busy; write-back clears it.
- Exposes source-busy flags so issue can stall on RAW hazards, and issue_ready so it can stall on WAW hazards.
- Optional write-to-read bypass.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREGS), register address width (derived; do not override)
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = reads see array contents only
ZERO_REG, 1, 1 = register 0 is hardwired zero, never written, never busy

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  source 1 has a pending write not yet written back
rs2_busy  out  1  source 2 has a pending write not yet written back
issue_valid  in  1  issue stage requests allocation of issue_rd
issue_rd  in  AW  destination register of issuing instruction
issue_ready  out  1  allocation accepted this cycle when issue_valid high
wb_valid  in  1  write-back valid
wb_rd  in  AW  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  synchronous clear of all busy bits (pipeline squash)

Behaviour:
- Reset (async, immediate): all NREGS registers = 0; all busy bits = 0. Hence rs*_data = 0, rs*_busy = 0, issue_ready = 1.
- Write: on posedge, if wb_valid, then regs[wb_rd] <= wb_data, except when ZERO_REG=1 and wb_rd=0 (write dropped).
- Write-back with the busy bit clear is legal: data is written and busy stays 0.
- Read: rs*_data = regs[rs*_addr], forced to 0 when ZERO_REG=1 and addr=0.
  - BYPASS=1: if wb_valid and wb_rd==rs*_addr (and it is not the hardwired zero register), rs*_data = wb_data in the same cycle.
- Busy flags, evaluated per source:
  - wb_clear(r) = wb_valid && wb_rd==r.
  - BYPASS=1: rs*_busy = busy[addr] && !wb_clear(addr).
  - BYPASS=0: rs*_busy = busy[addr]; the consumer stalls one extra cycle.
  - Register 0 is never busy when ZERO_REG=1.
- issue_ready = !busy[issue_rd] || wb_clear(issue_rd). issue_ready is 1 for the zero register. It is independent of issue_valid.
- Allocation: accepted when issue_valid && issue_ready. On posedge, busy[issue_rd] <= 1, skipped for the zero register.
- Busy update priority per register at posedge, highest first:
  1. flush: all busy bits <= 0; a same-cycle issue is discarded; the same-cycle write-back data is still written.
  2. Accepted issue to r: busy[r] <= 1, even if wb_clear(r) in the same cycle (new owner).
  3. wb_clear(r): busy[r] <= 0.
- Issue and write-back to different registers in the same cycle update independently.
- Reset mid-operation clears everything regardless of pending issue or write-back.
- Latency: write visible in the array the cycle after write-back, or in the same cycle via the bypass. Busy set is visible the cycle after issue.

Decomposition:
- Shared package core_pkg:
  - XLEN default;
  - register address width constant;
  - ZERO_REG_IDX = 0;
  - typedefs for register index and XLEN data word.
- One natural sub-module: regfile_read_port, instantiated twice. It holds the mux, zero-forcing, bypass and busy-flag logic for one read port.
- Storage array and busy vector stay in the top module.

Test Plan:
- Reset, then read x0..x31 -> all data 0, busy 0, issue_ready 1. Assert reset mid-cycle with busy[5]=1 -> busy[5] and data cleared immediately, without waiting for a clock edge.
- Write-back x0 = 32'hDEADBEEF, then read x0 -> 0. Issue x0 -> issue_ready 1 and x0 never busy.
- Issue x7; next cycle read rs1=x7 -> rs1_busy 1. Write-back x7 = 32'h1234_5678 with rs1=x7 in the same cycle: BYPASS=1 -> data 32'h12345678, busy 0; BYPASS=0 -> old data, busy 1, then correct value next cycle.
- busy[3]=1: issue x3 -> issue_ready 0, busy unchanged. Issue x3 with write-back x3 in the same cycle -> issue_ready 1 and busy[3] remains 1 after the edge.
- busy[2], busy[9] set; flush with issue x4 and write-back x9 = 5 in the same cycle -> all busy 0, regs[9]=5, x4 not busy.
- NREGS=16, XLEN=64: write 64'hFFFF_0000_FFFF_0000 to x15, read on both ports -> exact value; busy of x15 tracked correctly.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, register index and data word types.
package core_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int AW_DEF       = $clog2(NREGS_DEF);
    localparam int ZERO_REG_IDX = 0;

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_read_port.sv
// One register file read port: array mux, same-cycle write-back bypass,
// hardwired-zero forcing and the matching busy flag for the source.
module regfile_read_port
    import core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]               addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            busy_vec,
    input  logic                        wb_valid,
    input  logic [AW-1:0]               wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    output logic [XLEN-1:0]             data,
    output logic                        busy
);

    logic is_zero;
    logic wb_hit;

    assign is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_REG_IDX));
    assign wb_hit  = wb_valid && (wb_rd == addr);

    // Select array contents, override with in-flight write-back, then force x0.
    always_comb begin
        data = regs[addr];
        busy = busy_vec[addr];
        if ((BYPASS != 0) && wb_hit) begin
            // Data arrives this cycle, so the consumer need not stall.
            data = wb_data;
            busy = 1'b0;
        end
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one write-back
// port and a per-register busy scoreboard for RAW/WAW hazard stalls.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0]           busy_q, busy_d;

    logic                       wb_zero, issue_zero;
    logic [1:0][AW-1:0]         rd_addr;
    logic [1:0][XLEN-1:0]       rd_data;
    logic [1:0]                 rd_busy;

    assign wb_zero    = (ZERO_REG != 0) && (wb_rd == AW'(ZERO_REG_IDX));
    assign issue_zero = (ZERO_REG != 0) && (issue_rd == AW'(ZERO_REG_IDX));

    // A destination may be reallocated when idle or being retired this cycle.
    assign issue_ready = issue_zero || !busy_q[issue_rd] ||
                         (wb_valid && (wb_rd == issue_rd));

    // Write-back into the array; x0 writes are dropped when hardwired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (wb_valid && !wb_zero) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Busy next state: flush beats issue, issue beats write-back clear.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_valid) begin
                busy_d[wb_rd] = 1'b0;
            end
            if (issue_valid && issue_ready && !issue_zero) begin
                busy_d[issue_rd] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_REG_IDX] = 1'b0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_addr = {rs2_addr, rs1_addr};

    for (genvar g = 0; g < 2; g++) begin : g_rp
        regfile_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rp (
            .addr     (rd_addr[g]),
            .regs     (regs_q),
            .busy_vec (busy_q),
            .wb_valid (wb_valid),
            .wb_rd    (wb_rd),
            .wb_data  (wb_data),
            .data     (rd_data[g]),
            .busy     (rd_busy[g])
        );
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: bypass and non-bypass 32x32 instances share stimulus,
// plus a 16x64 instance for the wide configuration.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Shared stimulus for the two 32x32 instances.
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic        issue_valid, wb_valid, flush;
    logic [31:0] wb_data;

    logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic        a_rs1_busy, a_rs2_busy, a_ready;
    logic        b_rs1_busy, b_rs2_busy, b_ready;

    // Wide instance signals.
    logic [3:0]  w_rs1_addr, w_rs2_addr, w_issue_rd, w_wb_rd;
    logic        w_issue_valid, w_wb_valid, w_flush;
    logic [63:0] w_wb_data, w_rs1_data, w_rs2_data;
    logic        w_rs1_busy, w_rs2_busy, w_ready;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.BYPASS(1)) u_a (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(a_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
    );

    regfile_scoreboard #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(b_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
    );

    regfile_scoreboard #(.NREGS(16), .XLEN(64)) u_w (
        .clk(clk), .reset(reset),
        .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr),
        .rs1_data(w_rs1_data), .rs2_data(w_rs2_data),
        .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
        .issue_valid(w_issue_valid), .issue_rd(w_issue_rd), .issue_ready(w_ready),
        .wb_valid(w_wb_valid), .wb_rd(w_wb_rd), .wb_data(w_wb_data), .flush(w_flush)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rs1_addr = '0; rs2_addr = '0; issue_rd = '0; wb_rd = '0;
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; wb_data = '0;
    endtask

    task automatic widle();
        w_rs1_addr = '0; w_rs2_addr = '0; w_issue_rd = '0; w_wb_rd = '0;
        w_issue_valid = 1'b0; w_wb_valid = 1'b0; w_flush = 1'b0; w_wb_data = '0;
    endtask

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic        erdy;
    } vec_t;

    vec_t tbl[11];

    localparam logic [63:0] WVAL = 64'hFFFF_0000_FFFF_0000;

    initial begin
        // Per-cycle vectors for the bypass instance; outputs checked before the edge.
        tbl[0]  = '{1'b1, 5'd3, 32'hAAAA,     1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 32'hAAAA, 32'h0,    1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd3, 5'd5, 32'hAAAA, 32'h0,    1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd5, 5'd3, 32'h0,    32'hAAAA, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd5, 32'h55,       1'b1, 5'd5, 1'b0, 5'd5, 5'd3, 32'h55,   32'hAAAA, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd6, 1'b0, 5'd5, 5'd3, 32'h55,   32'hAAAA, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,    32'h55,   1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 5'd5, 32'h66,       1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 32'h0,    32'h66,   1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h66,   32'h0,    1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 1'b0, 5'd6, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 5'd6, 32'h77,       1'b1, 5'd8, 1'b1, 5'd6, 5'd8, 32'h77,   32'h0,    1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd8, 1'b0, 5'd6, 5'd8, 32'h77,   32'h0,    1'b0, 1'b0, 1'b1};

        idle();
        widle();
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_a_data", a_rs1_data, 0);
        chk("reset_w_data", w_rs1_data, 0);
        reset = 1'b0;

        // Whole file reads zero, idle, allocatable after reset.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); issue_rd = 5'(i);
            #1;
            chk("rst_rs1_data", a_rs1_data, 0);
            chk("rst_rs2_data", a_rs2_data, 0);
            chk("rst_rs1_busy", a_rs1_busy, 0);
            chk("rst_rs2_busy", b_rs2_busy, 0);
            chk("rst_ready",    a_ready,    1);
        end

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            wb_valid = tbl[i].wv; wb_rd = tbl[i].wrd; wb_data = tbl[i].wd;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird; flush = tbl[i].fl;
            rs1_addr = tbl[i].r1; rs2_addr = tbl[i].r2;
            #1;
            chk($sformatf("v%0d_rs1_data", i), a_rs1_data, tbl[i].e1);
            chk($sformatf("v%0d_rs2_data", i), a_rs2_data, tbl[i].e2);
            chk($sformatf("v%0d_rs1_busy", i), a_rs1_busy, tbl[i].eb1);
            chk($sformatf("v%0d_rs2_busy", i), a_rs2_busy, tbl[i].eb2);
            chk($sformatf("v%0d_ready", i),    a_ready,    tbl[i].erdy);
        end

        // Asynchronous reset between clock edges clears a busy register at once.
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd5;
        @(negedge clk); idle(); rs1_addr = 5'd5;
        #1;
        chk("pre_rst_a_busy", a_rs1_busy, 1);
        chk("pre_rst_b_busy", b_rs1_busy, 1);
        chk("pre_rst_a_data", a_rs1_data, 32'h66);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_a_busy", a_rs1_busy, 0);
        chk("async_rst_b_busy", b_rs1_busy, 0);
        chk("async_rst_a_data", a_rs1_data, 0);
        chk("async_rst_b_data", b_rs1_data, 0);
        #1 reset = 1'b0;

        // RAW on x7 with and without the bypass.
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clk); idle(); rs1_addr = 5'd7;
        #1;
        chk("x7_a_busy", a_rs1_busy, 1);
        chk("x7_b_busy", b_rs1_busy, 1);
        @(negedge clk); idle(); rs1_addr = 5'd7;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
        #1;
        chk("x7_wb_a_data", a_rs1_data, 32'h1234_5678);
        chk("x7_wb_a_busy", a_rs1_busy, 0);
        chk("x7_wb_b_data", b_rs1_data, 0);
        chk("x7_wb_b_busy", b_rs1_busy, 1);
        @(negedge clk); idle(); rs1_addr = 5'd7;
        #1;
        chk("x7_after_a_data", a_rs1_data, 32'h1234_5678);
        chk("x7_after_b_data", b_rs1_data, 32'h1234_5678);
        chk("x7_after_b_busy", b_rs1_busy, 0);

        // WAW on x3: blocked while busy, accepted as new owner when retiring.
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        chk("x3_first_ready", a_ready, 1);
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        chk("x3_waw_a_ready", a_ready, 0);
        chk("x3_waw_b_ready", b_ready, 0);
        @(negedge clk); idle(); rs1_addr = 5'd3;
        #1;
        chk("x3_still_busy", b_rs1_busy, 1);
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd3;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        #1;
        chk("x3_same_a_ready", a_ready, 1);
        chk("x3_same_b_ready", b_ready, 1);
        @(negedge clk); idle(); rs1_addr = 5'd3;
        #1;
        chk("x3_owner_a_busy", a_rs1_busy, 1);
        chk("x3_owner_b_busy", b_rs1_busy, 1);
        chk("x3_owner_data",   a_rs1_data, 32'h33);

        // Flush wins over a same-cycle issue but keeps the write-back data.
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd2;
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk); idle(); flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'd5;
        @(negedge clk); idle(); rs1_addr = 5'd2; rs2_addr = 5'd9; issue_rd = 5'd4;
        #1;
        chk("flush_x2_a_busy", a_rs1_busy, 0);
        chk("flush_x2_b_busy", b_rs1_busy, 0);
        chk("flush_x9_b_busy", b_rs2_busy, 0);
        chk("flush_x9_data",   b_rs2_data, 32'd5);
        chk("flush_x4_ready",  b_ready,    1);
        @(negedge clk); idle(); rs1_addr = 5'd4; rs2_addr = 5'd3;
        #1;
        chk("flush_x4_busy", a_rs1_busy, 0);
        chk("flush_x3_busy", a_rs2_busy, 0);

        // Wide configuration: 16 x 64.
        @(negedge clk); widle(); w_rs1_addr = 4'd15; w_rs2_addr = 4'd15;
        w_wb_valid = 1'b1; w_wb_rd = 4'd15; w_wb_data = WVAL;
        #1;
        chk("w_byp_rs1", w_rs1_data, WVAL);
        chk("w_byp_rs2", w_rs2_data, WVAL);
        @(negedge clk); widle(); w_rs1_addr = 4'd15; w_rs2_addr = 4'd15;
        w_issue_valid = 1'b1; w_issue_rd = 4'd15;
        #1;
        chk("w_arr_rs1",  w_rs1_data, WVAL);
        chk("w_arr_rs2",  w_rs2_data, WVAL);
        chk("w_idle_bsy", w_rs1_busy, 0);
        @(negedge clk); widle(); w_rs1_addr = 4'd15; w_rs2_addr = 4'd15; w_issue_rd = 4'd15;
        #1;
        chk("w_busy_rs1", w_rs1_busy, 1);
        chk("w_busy_rs2", w_rs2_busy, 1);
        chk("w_ready",    w_ready,    0);
        @(negedge clk); widle(); w_rs1_addr = 4'd15; w_rs2_addr = 4'd14;
        w_wb_valid = 1'b1; w_wb_rd = 4'd15; w_wb_data = ~WVAL;
        #1;
        chk("w_wb_busy", w_rs1_busy, 0);
        chk("w_wb_data", w_rs1_data, ~WVAL);
        chk("w_x14",     w_rs2_data, 0);
        @(negedge clk); widle(); w_rs1_addr = 4'd15;
        #1;
        chk("w_final_busy", w_rs1_busy, 0);
        chk("w_final_data", w_rs1_data, ~WVAL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
